// File: rtl/display_scan.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered data.
// New data is held pending and only swapped into the display at a frame edge.
module display_scan #(
  parameter int DIVIDER = 100000,
  parameter int BLANK   = 1000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iData,
  input  logic        iLoad,
  input  logic [7:0]  iBlankMask,
  input  logic [7:0]  iDp,
  output logic [7:0]  oAn,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic        oAck,
  output logic        oFrame
);

  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ack_q, ack_d;
  logic          frame_q, frame_d;

  logic [6:0]    digit_seg [8];
  logic          frame_edge;
  logic          dark;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign digit_seg[gi] = seg_decode(disp_q[4*gi +: 4]);
  end

  always_comb begin
    frame_edge  = (cnt_q == CNT_LAST) && (idx_q == 3'd7);
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d       = (cnt_q == CNT_LAST) ? idx_q + 3'd1 : idx_q;

    // Dead time at slot start avoids ghosting while anodes switch.
    dark        = (cnt_q < CNT_BLANK) || iBlankMask[idx_q];
    an_d        = dark ? 8'hFF : ~(8'h01 << idx_q);
    seg_d       = dark ? 7'h7F : digit_seg[idx_q];
    dp_d        = dark ? 1'b1 : ~iDp[idx_q];

    frame_d     = frame_edge;
    ack_d       = 1'b0;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;

    if (frame_edge && pend_q) begin
      disp_d = pend_data_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    // A load on the commit cycle re-arms pending with the fresh value.
    if (iLoad) begin
      pend_data_d = iData;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      disp_q      <= 32'd0;
      pend_data_q <= 32'd0;
      pend_q      <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      ack_q       <= ack_d;
      frame_q     <= frame_d;
    end
  end

  assign oAn    = an_q;
  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oAck   = ack_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIVIDER=4, BLANK=1 (32-cycle frame).
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        load;
  logic [7:0]  bmask;
  logic [7:0]  dp_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ack;
  logic        frame;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pos;
  logic [31:0] exp_disp;
  logic [31:0] commit_val;
  logic        commit_flag;
  logic [6:0]  seg_tab [16];

  display_scan #(.DIVIDER(4), .BLANK(1)) dut (
    .iClk(clk), .iRst(rst), .iData(data), .iLoad(load),
    .iBlankMask(bmask), .iDp(dp_in),
    .oAn(an), .oSeg(seg), .oDp(dp), .oAck(ack), .oFrame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock; outputs after the edge reflect the scan position before it.
  task automatic tick();
    logic [2:0] di;
    logic       drk;
    logic [3:0] nib;
    @(posedge clk); #1;
    di  = 3'(pos / 4);
    drk = ((pos % 4) < 1) || bmask[di];
    nib = exp_disp[4*di +: 4];
    chk($sformatf("an@%0d", pos), {24'd0, an}, drk ? 32'hFF : {24'd0, ~(8'h01 << di)});
    chk($sformatf("seg@%0d", pos), {25'd0, seg}, drk ? 32'h7F : {25'd0, seg_tab[nib]});
    chk($sformatf("dp@%0d", pos), {31'd0, dp}, drk ? 32'd1 : {31'd0, ~dp_in[di]});
    chk($sformatf("frame@%0d", pos), {31'd0, frame}, (pos == 31) ? 32'd1 : 32'd0);
    chk($sformatf("ack@%0d", pos), {31'd0, ack}, (pos == 31 && commit_flag) ? 32'd1 : 32'd0);
    $display("[TB] pos=%0d an=%b seg=%b dp=%b ack=%b frame=%b", pos, an, seg, dp, ack, frame);
    if (pos == 31 && commit_flag) begin
      exp_disp    = commit_val;
      commit_flag = 1'b0;
    end
    pos = (pos + 1) % 32;
  endtask

  task automatic do_load(input logic [31:0] d);
    load = 1'b1;
    data = d;
    tick();
    load = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},    {24'd0, an},    32'hFF);
    chk({tag, "_seg"},   {25'd0, seg},   32'h7F);
    chk({tag, "_dp"},    {31'd0, dp},    32'd1);
    chk({tag, "_ack"},   {31'd0, ack},   32'd0);
    chk({tag, "_frame"}, {31'd0, frame}, 32'd0);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    rst = 1'b1; load = 1'b0; data = 32'd0; bmask = 8'd0; dp_in = 8'd0;
    exp_disp = 32'd0; commit_val = 32'd0; commit_flag = 1'b0; pos = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Free-running scan of zeros
    repeat (32) tick();

    // Mid-frame load commits only at the frame edge
    repeat (10) tick();
    commit_val = 32'h76543210; commit_flag = 1'b1;
    do_load(32'h76543210);
    repeat (53) tick();

    // Blank nibble, blank mask on digit 2, decimal point on digit 0
    bmask = 8'b0000_0100; dp_in = 8'h01;
    commit_val = 32'hA1234A60; commit_flag = 1'b1;
    do_load(32'hA1234A60);
    repeat (63) tick();

    // Load on the frame-edge cycle while an older value is pending
    repeat (5) tick();
    commit_val = 32'h13572468; commit_flag = 1'b1;
    do_load(32'h13572468);
    repeat (25) tick();
    load = 1'b1; data = 32'h98765432;
    tick();
    load = 1'b0;
    commit_val = 32'h98765432; commit_flag = 1'b1;
    repeat (32) tick();

    // Load on the frame-edge cycle with nothing pending
    repeat (31) tick();
    load = 1'b1; data = 32'h24680135;
    tick();
    load = 1'b0;
    commit_val = 32'h24680135; commit_flag = 1'b1;
    repeat (32) tick();

    // Reset at digit 5 with a load pending and a load on the reset cycle
    bmask = 8'd0; dp_in = 8'hF0;
    repeat (16) tick();
    do_load(32'h55555555);
    repeat (5) tick();
    rst = 1'b1; load = 1'b1; data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk_reset("midrst");
    rst = 1'b0; load = 1'b0;
    pos = 0; exp_disp = 32'd0; commit_flag = 1'b0;
    repeat (64) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
